// File: rtl/sar_search.sv
// Successive-approximation search: drives comparator data2 (probe), reads lt/gt/eq back, finds largest probe <= target.
// Optional macro SAR_EARLY_EXIT_EN: a consistent eq ends the search at once instead of running all WIDTH decisions.
module sar_search #(
    parameter int WIDTH  = 16,
    parameter int SETTLE = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             cmp_lt,
    input  logic             cmp_gt,
    input  logic             cmp_eq,
    output logic [WIDTH-1:0] probe,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             exact,
    output logic             err
);

    localparam int                IW          = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IW-1:0]     TOP_IDX     = IW'(WIDTH - 1);
    localparam logic [IW-1:0]     ONE_IDX     = IW'(1);
    localparam logic [3:0]        SETTLE_INIT = 4'(SETTLE);
    localparam logic [WIDTH-1:0]  ONE         = WIDTH'(1);
    localparam logic [WIDTH-1:0]  FIRST_PROBE = ONE << (WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_TRIAL,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_probe;
    logic [IW-1:0]    r_idx;
    logic [3:0]       r_settle;
    logic [WIDTH-1:0] r_result;
    logic             r_exact;
    logic             r_err;

    state_t           w_state_nxt;
    logic [WIDTH-1:0] w_probe_nxt;
    logic [IW-1:0]    w_idx_nxt;
    logic [3:0]       w_settle_nxt;
    logic [WIDTH-1:0] w_result_nxt;
    logic             w_exact_nxt;
    logic             w_err_nxt;

    logic             w_flags_ok;
    logic             w_eq_stop;
    logic [WIDTH-1:0] w_bit_cur;
    logic [WIDTH-1:0] w_bit_next;
    logic [WIDTH-1:0] w_kept;

    assign w_flags_ok = $onehot({cmp_lt, cmp_gt, cmp_eq});

`ifdef SAR_EARLY_EXIT_EN
    assign w_eq_stop  = cmp_eq;
`else
    assign w_eq_stop  = 1'b0;
`endif

    // w_bit_next is only consumed when r_idx > 0, so the wrap at index 0 is harmless.
    assign w_bit_cur  = ONE << r_idx;
    assign w_bit_next = ONE << (r_idx - ONE_IDX);
    assign w_kept     = cmp_lt ? (r_probe & ~w_bit_cur) : r_probe;

    always_comb begin
        // NOTE: every next-value gets a hold default before the case, so no path can infer a latch.
        w_state_nxt  = r_state;
        w_probe_nxt  = r_probe;
        w_idx_nxt    = r_idx;
        w_settle_nxt = r_settle;
        w_result_nxt = r_result;
        w_exact_nxt  = r_exact;
        w_err_nxt    = r_err;

        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_probe_nxt  = FIRST_PROBE;
                    w_idx_nxt    = TOP_IDX;
                    w_settle_nxt = SETTLE_INIT;
                    w_exact_nxt  = 1'b0;
                    w_err_nxt    = 1'b0;
                    w_state_nxt  = S_TRIAL;
                end
            end

            S_TRIAL: begin
                if (abort) begin
                    w_state_nxt = S_IDLE;
                end else if (r_settle != 4'd0) begin
                    w_settle_nxt = r_settle - 4'd1;
                end else if (!w_flags_ok) begin
                    w_err_nxt    = 1'b1;
                    w_result_nxt = r_probe;
                    w_state_nxt  = S_DONE;
                end else if (w_eq_stop) begin
                    w_exact_nxt  = 1'b1;
                    w_result_nxt = r_probe;
                    w_state_nxt  = S_DONE;
                end else begin
                    // Without early exit an eq keeps the bit (like gt) and only latches exact.
                    if (cmp_eq) begin
                        w_exact_nxt = 1'b1;
                    end
                    if (r_idx == '0) begin
                        w_result_nxt = w_kept;
                        w_state_nxt  = S_DONE;
                    end else begin
                        w_probe_nxt  = w_kept | w_bit_next;
                        w_idx_nxt    = r_idx - ONE_IDX;
                        w_settle_nxt = SETTLE_INIT;
                    end
                end
            end

            S_DONE: begin
                w_state_nxt = S_IDLE;
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_probe  <= '0;
            r_idx    <= TOP_IDX;
            r_settle <= 4'd0;
            r_result <= '0;
            r_exact  <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            // NOTE: non-blocking updates so every register sees the pre-edge values of the others.
            r_state  <= w_state_nxt;
            r_probe  <= w_probe_nxt;
            r_idx    <= w_idx_nxt;
            r_settle <= w_settle_nxt;
            r_result <= w_result_nxt;
            r_exact  <= w_exact_nxt;
            r_err    <= w_err_nxt;
        end
    end

    assign probe  = r_probe;
    assign busy   = (r_state == S_TRIAL);
    assign done   = (r_state == S_DONE);
    assign result = r_result;
    assign exact  = r_exact;
    assign err    = r_err;

endmodule

// File: tb/tb_sar_search.sv
// Directed bench for sar_search: one instance with SETTLE=0, one with SETTLE=2, each wired to a comparator model.
module tb_sar_search;

    localparam int W = 16;

`ifdef SAR_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic         clk;
    logic         rst;
    logic         start0, abort0, start2, abort2;
    logic         lt0, gt0, eq0, lt2, gt2, eq2;
    logic [W-1:0] probe0, result0, probe2, result2;
    logic         busy0, done0, exact0, err0;
    logic         busy2, done2, exact2, err2;

    logic [W-1:0] tgt0, tgt2;
    logic         bad0;
    logic         cur2;
    logic [W-1:0] last_p2 = '0;
    logic         was_busy2 = 1'b0;
    int           age2 = 0;

    int n_total = 0;
    int n_bad   = 0;

    typedef struct {
        bit           sel2;
        bit           force_bad;
        bit           fixed_dec;
        logic [W-1:0] target;
        logic [W-1:0] exp_result;
        bit           exp_exact;
        bit           exp_err;
        int           eq_dec;
        int           restart_at;
        bit           poke_done;
    } vec_t;

    vec_t vecs [10];

    sar_search #(.WIDTH(W), .SETTLE(0)) u_dut0 (
        .clk(clk), .rst(rst), .start(start0), .abort(abort0),
        .cmp_lt(lt0), .cmp_gt(gt0), .cmp_eq(eq0),
        .probe(probe0), .busy(busy0), .done(done0),
        .result(result0), .exact(exact0), .err(err0)
    );

    sar_search #(.WIDTH(W), .SETTLE(2)) u_dut2 (
        .clk(clk), .rst(rst), .start(start2), .abort(abort2),
        .cmp_lt(lt2), .cmp_gt(gt2), .cmp_eq(eq2),
        .probe(probe2), .busy(busy2), .done(done2),
        .result(result2), .exact(exact2), .err(err2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Ideal comparator for dut0, with an optional forced lt=gt fault when probe reaches 0xE000.
    always_comb begin
        lt0 = 1'b0;
        gt0 = 1'b0;
        eq0 = 1'b0;
        if (bad0 && probe0 == 16'hE000) begin
            lt0 = 1'b1;
            gt0 = 1'b1;
        end else begin
            lt0 = (tgt0 < probe0);
            gt0 = (tgt0 > probe0);
            eq0 = (tgt0 == probe0);
        end
    end

    // Slow comparator for dut2: flags are garbage until a probe has been stable for two cycles.
    always @(negedge clk) begin
        age2      <= (probe2 != last_p2 || !was_busy2) ? 0 : age2 + 1;
        last_p2   <= probe2;
        was_busy2 <= busy2;
    end

    always_comb begin
        lt2 = 1'b1;
        gt2 = 1'b1;
        eq2 = 1'b1;
        if (age2 >= 2) begin
            lt2 = (tgt2 < probe2);
            gt2 = (tgt2 > probe2);
            eq2 = (tgt2 == probe2);
        end
    end

    logic [W-1:0] m_probe, m_result;
    logic         m_busy, m_done, m_exact, m_err;
    always_comb begin
        m_probe  = cur2 ? probe2  : probe0;
        m_result = cur2 ? result2 : result0;
        m_busy   = cur2 ? busy2   : busy0;
        m_done   = cur2 ? done2   : done0;
        m_exact  = cur2 ? exact2  : exact0;
        m_err    = cur2 ? err2    : err0;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic pulse_start(input bit sel2, input bit val);
        if (sel2) start2 = val;
        else      start0 = val;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int dec;
        int edges;
        int exp_cycles;
        bit seen;
        cur2 = v.sel2;
        bad0 = v.force_bad;
        if (v.sel2) tgt2 = v.target;
        else        tgt0 = v.target;
        dec        = (EARLY || v.fixed_dec) ? v.eq_dec : W;
        exp_cycles = dec * (v.sel2 ? 3 : 1) + 1;

        @(negedge clk);
        pulse_start(v.sel2, 1'b1);
        @(posedge clk); #1;
        pulse_start(v.sel2, 1'b0);
        check($sformatf("v%0d first_probe", idx), m_probe, 16'h8000);
        check($sformatf("v%0d busy", idx), m_busy, 1);

        edges = 0;
        seen  = 1'b0;
        while (!seen && edges < 200) begin
            if (v.restart_at != 0 && edges == v.restart_at) pulse_start(v.sel2, 1'b1);
            @(posedge clk); #1;
            pulse_start(v.sel2, 1'b0);
            edges++;
            if (v.sel2 && edges < 3) check($sformatf("v%0d probe_hold", idx), m_probe, 16'h8000);
            seen = m_done;
        end
        check($sformatf("v%0d done_seen", idx), seen, 1);
        check($sformatf("v%0d done_cycle", idx), edges + 1, exp_cycles);
        check($sformatf("v%0d result", idx), m_result, v.exp_result);
        check($sformatf("v%0d exact", idx), m_exact, v.exp_exact);
        check($sformatf("v%0d err", idx), m_err, v.exp_err);
        check($sformatf("v%0d busy_in_done", idx), m_busy, 0);

        if (v.poke_done) pulse_start(v.sel2, 1'b1);
        @(posedge clk); #1;
        pulse_start(v.sel2, 1'b0);
        check($sformatf("v%0d done_one_cycle", idx), m_done, 0);
        check($sformatf("v%0d idle_after_done", idx), m_busy, 0);
        check($sformatf("v%0d result_held", idx), m_result, v.exp_result);
        bad0 = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit saw_done;
        //          sel2 bad fix target    result    ex err dec rst poke
        vecs[0] = '{0, 0, 0, 16'h8000, 16'h8000, 1, 0, 1,  0, 0};
        vecs[1] = '{0, 0, 0, 16'h0000, 16'h0000, 0, 0, 16, 0, 0};
        vecs[2] = '{0, 0, 0, 16'hFFFF, 16'hFFFF, 1, 0, 16, 0, 0};
        vecs[3] = '{0, 0, 0, 16'h4000, 16'h4000, 1, 0, 2,  0, 0};
        vecs[4] = '{0, 0, 0, 16'hA5A0, 16'hA5A0, 1, 0, 11, 0, 0};
        vecs[5] = '{0, 0, 0, 16'h0001, 16'h0001, 1, 0, 16, 0, 0};
        vecs[6] = '{0, 0, 0, 16'h0F0F, 16'h0F0F, 1, 0, 16, 3, 1};
        vecs[7] = '{1, 0, 0, 16'h1234, 16'h1234, 1, 0, 14, 0, 0};
        vecs[8] = '{1, 0, 0, 16'h0000, 16'h0000, 0, 0, 16, 0, 0};
        vecs[9] = '{0, 1, 1, 16'hF000, 16'hE000, 0, 1, 3,  0, 0};

        start0 = 1'b0; abort0 = 1'b0; start2 = 1'b0; abort2 = 1'b0;
        tgt0 = '0; tgt2 = '0; bad0 = 1'b0; cur2 = 1'b0;
        rst = 1'b0;
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset probe", probe0, 0);
        check("reset busy", busy0, 0);
        check("reset done", done0, 0);
        check("reset result", result0, 0);
        check("reset exact", exact0, 0);
        check("reset err", err0, 0);
        check("reset probe2", probe2, 0);
        check("reset busy2", busy2, 0);
        @(negedge clk) rst = 1'b0;

        for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

        // Abort on decision 5 of target 0x5555: probe has reached 0x5800, last result 0xE000 stays.
        cur2 = 1'b0;
        tgt0 = 16'h5555;
        @(negedge clk) start0 = 1'b1;
        @(posedge clk); #1 start0 = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("abort probe_before", probe0, 16'h5800);
        abort0 = 1'b1;
        @(posedge clk); #1 abort0 = 1'b0;
        check("abort busy", busy0, 0);
        check("abort done", done0, 0);
        check("abort probe", probe0, 16'h5800);
        check("abort result", result0, 16'hE000);
        check("abort exact", exact0, 0);
        saw_done = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            if (done0) saw_done = 1'b1;
        end
        check("abort no_done", saw_done, 0);

        // Asynchronous reset in the middle of a search.
        tgt0 = 16'h1234;
        @(negedge clk) start0 = 1'b1;
        @(posedge clk); #1 start0 = 1'b0;
        repeat (5) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("midrst probe", probe0, 0);
        check("midrst busy", busy0, 0);
        check("midrst done", done0, 0);
        check("midrst result", result0, 0);
        check("midrst exact", exact0, 0);
        check("midrst err", err0, 0);
        @(negedge clk) rst = 1'b0;
        saw_done = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            if (done0) saw_done = 1'b1;
        end
        check("midrst no_done", saw_done, 0);

        run_vec(vecs[2], 10);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
